control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Controller for the 4-bit bus CPU datapath (PC, MAR, RAM, IR, Accumulator A, B, ALU, Out).
//  Steps T-states, decodes the IR opcode and drives every datapath strobe.
//  Each instruction is fetched, then executed over a variable number of states.
//  Supports free-run and single-step modes, and halts on HLT.
// PARAMETERS
//  OP_W           4  opcode width (IR upper nibble)
//  HALT_ON_UNDEF  0  1: undefined opcodes halt; 0: undefined opcodes execute as NOP
// PORTS
//  MainClock  in   1     single clock, all state changes on rising edge
//  ClearAll   in   1     synchronous, active-high reset
//  Run        in   1     1 = sequencer may advance
//  StepMode   in   1     1 = advance once per StepPulse rising edge
//  StepPulse  in   1     single-step request (level, debounced/synchronised upstream)
//  Opcode     in   OP_W  IR upper nibble, valid from T3 onward
//  EnablePC, EnableRAM, EnableIR, EnableA, EnableALU  out 1  bus driver enables
//  LatchMAR, LatchIR, LatchA, LatchB, LatchOut, IncPC, ClearA  out 1  register strobes
//  Sub        out  1     ALU subtract select
//  TState     out  3     current T-state, 1..6 (debug display)
//  Halted     out  1     1 while in HALT
// BEHAVIOUR
//  - Reset (ClearAll=1 at edge): TState=1, Halted=0, step edge register=0.
//    Every strobe and enable is 0 while ClearAll is high.
//    Reset wins over every other input, including mid-instruction and in HALT.
//  - Advance = Run & ~Halted & (~StepMode | (StepPulse & ~step_q)).
//    step_q is StepPulse registered every cycle.
//  - TState updates only on Advance: on last state of instruction -> 1, else +1.
//  - Strobes (Latch*, IncPC, ClearA) are the decode AND Advance, so each fires exactly once per T-state.
//    Enables and Sub are ungated decode of (TState, Opcode).
//  - Decode; "->end" means the instruction's last state:
//    T1 all:       EnablePC, LatchMAR
//    T2 all:       EnableRAM, LatchIR, IncPC
//    T3 LDA/ADD/SUB: EnableIR, LatchMAR
//    T3 OUT:       EnableA, LatchOut ->end
//    T3 CLRA:      ClearA ->end
//    T3 NOP/undef: none ->end
//    T3 HLT:       on Advance set Halted=1; TState holds 3
//    T4 LDA:       EnableRAM, LatchA ->end
//    T4 ADD/SUB:   EnableRAM, LatchB
//    T5 ADD:       EnableALU, LatchA ->end
//    T5 SUB:       EnableALU, Sub, LatchA ->end
//  - Opcodes: LDA=0000, ADD=0001, SUB=0010, CLRA=0011, NOP=0100, OUT=1110, HLT=1111.
//    Any other value is undefined.
//  - T6 is reserved. Reaching it is an error; the next Advance returns to T1.
//  - HALT: all outputs 0 except Halted=1 and TState=3. Only ClearAll exits.
//  - Run=0 or a stalled step: state frozen, strobes 0, enables keep their decode.
//  - StepMode may change at any cycle. The new mode takes effect on the same cycle's Advance.
//  - At most one Enable* is high in any cycle; this is a bus-contention invariant.
// STRUCTURE
//  - Package sap_ctrl_pkg: opcode localparams, T-state localparams T1..T6, strobe-bundle bit indices.
//  - Sub-module step_edge_detect: holds step_q and outputs a one-cycle rise pulse.
//  - Top: TState register, Halted flag, a combinational decode case, and Advance gating.
// TESTING
//  1 Reset, Run=1, StepMode=0, Opcode=LDA -> TState 1,2,3,4,1.
//    LatchA pulses once, in T4 with EnableRAM.
//  2 Opcode=SUB -> T5 shows EnableALU=1, Sub=1, LatchA=1 for exactly one cycle.
//    Next cycle TState=1.
//  3 Opcode=HLT -> Halted=1 after the T3 edge, then all strobes 0 for 20 cycles.
//    ClearAll -> TState=1, Halted=0.
//  4 StepMode=1, StepPulse held high 5 cycles -> exactly one advance (T1->T2).
//    Exactly one LatchMAR pulse.
//  5 ClearAll asserted at T4 of ADD -> next cycle TState=1, no LatchB pulse, all outputs 0.
//  6 Random opcodes over 1000 cycles -> at most one Enable* high per cycle.
//    IncPC count equals instructions fetched; opcode 0101 behaves as NOP (3 states).

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared encodings for the SAP-style control sequencer: opcodes, T-states
// and bit positions inside the enable and strobe bundles.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_CLRA = 4'b0011;
  localparam logic [3:0] OP_NOP  = 4'b0100;
  localparam logic [3:0] OP_OUT  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;

  localparam int STB_LATCH_MAR = 0;
  localparam int STB_LATCH_IR  = 1;
  localparam int STB_LATCH_A   = 2;
  localparam int STB_LATCH_B   = 3;
  localparam int STB_LATCH_OUT = 4;
  localparam int STB_INC_PC    = 5;
  localparam int STB_CLEAR_A   = 6;
  localparam int STB_W         = 7;

  localparam int EN_PC  = 0;
  localparam int EN_RAM = 1;
  localparam int EN_IR  = 2;
  localparam int EN_A   = 3;
  localparam int EN_ALU = 4;
  localparam int EN_W   = 5;

  typedef logic [STB_W-1:0] strobe_t;
  typedef logic [EN_W-1:0]  enable_t;

  // One decoded control word for the current (TState, Opcode).
  typedef struct packed {
    enable_t en;
    logic    sub;
    strobe_t stb;
    logic    last;
    logic    halt;
  } decode_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Front-panel inputs, IR opcode and datapath strobes of the control sequencer.
// master = the sequencer, slave = datapath / front panel side.
interface control_sequencer_if #(parameter int OP_W = 4);
  logic            Run;
  logic            StepMode;
  logic            StepPulse;
  logic [OP_W-1:0] Opcode;
  logic            EnablePC, EnableRAM, EnableIR, EnableA, EnableALU;
  logic            LatchMAR, LatchIR, LatchA, LatchB, LatchOut, IncPC, ClearA;
  logic            Sub;
  logic [2:0]      TState;
  logic            Halted;

  modport master (
    input  Run, StepMode, StepPulse, Opcode,
    output EnablePC, EnableRAM, EnableIR, EnableA, EnableALU,
    output LatchMAR, LatchIR, LatchA, LatchB, LatchOut, IncPC, ClearA,
    output Sub, TState, Halted
  );

  modport slave (
    output Run, StepMode, StepPulse, Opcode,
    input  EnablePC, EnableRAM, EnableIR, EnableA, EnableALU,
    input  LatchMAR, LatchIR, LatchA, LatchB, LatchOut, IncPC, ClearA,
    input  Sub, TState, Halted
  );
endinterface

// File: rtl/step_edge_detect.sv
// Registers the step request every cycle and flags its rising edge, so a
// held StepPulse yields a single advance.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic rise_o
);
  logic step_q, step_d;

  always_comb step_d = pulse_i;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step_d;
  end

  assign rise_o = pulse_i & ~step_q;
endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer and instruction decoder for the 4-bit bus CPU; strobes
// fire once per advanced T-state, enables follow the decode of the state.
module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W          = 4,
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic                MainClock,
  input  logic                ClearAll,
  control_sequencer_if.master bus
);
  logic [2:0] tstate_q, tstate_d;
  logic       halted_q, halted_d;
  logic       step_rise, advance, live;
  decode_t    dec;
  enable_t    en;
  strobe_t    stb;

  step_edge_detect u_step (
    .clk    (MainClock),
    .rst    (ClearAll),
    .pulse_i(bus.StepPulse),
    .rise_o (step_rise)
  );

  assign advance = bus.Run & ~halted_q & (~bus.StepMode | step_rise);

  always_comb begin
    dec = '0;
    case (tstate_q)
      T1: begin
        dec.en[EN_PC]             = 1'b1;
        dec.stb[STB_LATCH_MAR]    = 1'b1;
      end
      T2: begin
        dec.en[EN_RAM]            = 1'b1;
        dec.stb[STB_LATCH_IR]     = 1'b1;
        dec.stb[STB_INC_PC]       = 1'b1;
      end
      T3: begin
        case (bus.Opcode)
          OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
            dec.en[EN_IR]          = 1'b1;
            dec.stb[STB_LATCH_MAR] = 1'b1;
          end
          OP_W'(OP_OUT): begin
            dec.en[EN_A]           = 1'b1;
            dec.stb[STB_LATCH_OUT] = 1'b1;
            dec.last               = 1'b1;
          end
          OP_W'(OP_CLRA): begin
            dec.stb[STB_CLEAR_A]   = 1'b1;
            dec.last               = 1'b1;
          end
          OP_W'(OP_HLT): dec.halt  = 1'b1;
          OP_W'(OP_NOP): dec.last  = 1'b1;
          default: begin
            dec.halt = HALT_ON_UNDEF;
            dec.last = ~HALT_ON_UNDEF;
          end
        endcase
      end
      T4: begin
        case (bus.Opcode)
          OP_W'(OP_LDA): begin
            dec.en[EN_RAM]         = 1'b1;
            dec.stb[STB_LATCH_A]   = 1'b1;
            dec.last               = 1'b1;
          end
          OP_W'(OP_ADD), OP_W'(OP_SUB): begin
            dec.en[EN_RAM]         = 1'b1;
            dec.stb[STB_LATCH_B]   = 1'b1;
          end
          default: dec.last = 1'b1;
        endcase
      end
      T5: begin
        dec.last = 1'b1;
        if (bus.Opcode == OP_W'(OP_ADD) || bus.Opcode == OP_W'(OP_SUB)) begin
          dec.en[EN_ALU]       = 1'b1;
          dec.stb[STB_LATCH_A] = 1'b1;
          dec.sub              = (bus.Opcode == OP_W'(OP_SUB));
        end
      end
      // T6 and out-of-range codes are unreachable; recover to T1 on the next advance.
      T6:      dec.last = 1'b1;
      default: dec.last = 1'b1;
    endcase
  end

  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (advance) begin
      if (dec.halt)      halted_d = 1'b1;
      else if (dec.last) tstate_d = T1;
      else               tstate_d = tstate_q + 3'd1;
    end
  end

  always_ff @(posedge MainClock) begin
    if (ClearAll) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  assign live = ~ClearAll & ~halted_q;
  assign en   = dec.en & {EN_W{live}};
  assign stb  = dec.stb & {STB_W{advance & ~ClearAll}};

  assign bus.EnablePC  = en[EN_PC];
  assign bus.EnableRAM = en[EN_RAM];
  assign bus.EnableIR  = en[EN_IR];
  assign bus.EnableA   = en[EN_A];
  assign bus.EnableALU = en[EN_ALU];
  assign bus.Sub       = dec.sub & live;
  assign bus.LatchMAR  = stb[STB_LATCH_MAR];
  assign bus.LatchIR   = stb[STB_LATCH_IR];
  assign bus.LatchA    = stb[STB_LATCH_A];
  assign bus.LatchB    = stb[STB_LATCH_B];
  assign bus.LatchOut  = stb[STB_LATCH_OUT];
  assign bus.IncPC     = stb[STB_INC_PC];
  assign bus.ClearA    = stb[STB_CLEAR_A];
  assign bus.TState    = tstate_q;
  assign bus.Halted    = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized checks of control_sequencer against an
// instruction-level model (per-opcode length and micro-op table).
module tb_control_sequencer;
  localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, CLRA = 4'h3,
                         NOP = 4'h4, OUTI = 4'hE, HLT = 4'hF;
  // control word bit positions: {EnPC,EnRAM,EnIR,EnA,EnALU,Sub,MAR,IR,A,B,Out,Inc,ClrA}
  localparam int W_PC = 12, W_RAM = 11, W_IR = 10, W_A = 9, W_ALU = 8, W_SUB = 7;
  localparam int W_MAR = 6, W_LIR = 5, W_LA = 4, W_LB = 3, W_LOUT = 2, W_INC = 1, W_CLA = 0;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_sequencer_if #(.OP_W(4)) bus ();
  control_sequencer #(.OP_W(4), .HALT_ON_UNDEF(1'b0)) dut (
    .MainClock(clk), .ClearAll(clr), .bus(bus)
  );

  int n_tests = 0, n_fail = 0;
  int m_t = 1;
  bit m_halt = 0, m_stepq = 0, m_adv = 0;
  int m_fetched = 0, inc_seen = 0;
  logic [12:0] exp_w, act_w;

  function automatic int instr_len(logic [3:0] op);
    if (op == LDA) return 4;
    if (op == ADD || op == SUB) return 5;
    return 3;
  endfunction

  function automatic logic [12:0] ucode(int t, logic [3:0] op);
    logic [12:0] w = '0;
    if (t == 1) begin w[W_PC] = 1; w[W_MAR] = 1; end
    else if (t == 2) begin w[W_RAM] = 1; w[W_LIR] = 1; w[W_INC] = 1; end
    else if (t == 3) begin
      if (op == LDA || op == ADD || op == SUB) begin w[W_IR] = 1; w[W_MAR] = 1; end
      else if (op == OUTI) begin w[W_A] = 1; w[W_LOUT] = 1; end
      else if (op == CLRA) w[W_CLA] = 1;
    end else if (t == 4) begin
      if (op == LDA) begin w[W_RAM] = 1; w[W_LA] = 1; end
      else if (op == ADD || op == SUB) begin w[W_RAM] = 1; w[W_LB] = 1; end
    end else if (t == 5) begin
      if (op == ADD || op == SUB) begin w[W_ALU] = 1; w[W_LA] = 1; w[W_SUB] = (op == SUB); end
    end
    return w;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic sample();
    #1;
    m_adv = bus.Run && !m_halt && (!bus.StepMode || (bus.StepPulse && !m_stepq));
    if (clr || m_halt) exp_w = '0;
    else begin
      exp_w = ucode(m_t, bus.Opcode);
      if (!m_adv) exp_w[6:0] = '0;
    end
    act_w = {bus.EnablePC, bus.EnableRAM, bus.EnableIR, bus.EnableA, bus.EnableALU, bus.Sub,
             bus.LatchMAR, bus.LatchIR, bus.LatchA, bus.LatchB, bus.LatchOut, bus.IncPC, bus.ClearA};
    if (act_w[W_INC]) inc_seen++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (clr) begin
      m_t = 1; m_halt = 0; m_stepq = 0;
    end else begin
      if (m_adv) begin
        if (m_t == 3 && bus.Opcode == HLT) m_halt = 1;
        else if (m_t >= instr_len(bus.Opcode)) m_t = 1;
        else begin
          if (m_t == 2) m_fetched++;
          m_t++;
        end
      end
      m_stepq = bus.StepPulse;
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1; sample(); advance(); clr = 0;
  endtask

  task automatic test_reset();
    clr = 1; bus.Run = 1; bus.StepMode = 1; bus.StepPulse = 1; bus.Opcode = ADD;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_tests++;
      if (act_w !== 13'd0) begin n_fail++; $display("FAIL reset_outputs got=%b want=0", act_w); end
      advance();
    end
    n_tests++;
    if (bus.TState !== 3'd1 || bus.Halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got T=%0d H=%b want T=1 H=0", bus.TState, bus.Halted);
    end
    // step edge register cleared: held pulse right after reset counts as a rise
    clr = 0;
    sample(); advance();
    n_tests++;
    if (bus.TState !== 3'd2) begin n_fail++; $display("FAIL reset_stepq got T=%0d want 2", bus.TState); end
  endtask

  task automatic test_lda();
    int seq[5] = '{1, 2, 3, 4, 1};
    int la = 0;
    do_clear();
    bus.Run = 1; bus.StepMode = 0; bus.StepPulse = 0; bus.Opcode = LDA;
    for (int i = 0; i < 5; i++) begin
      sample();
      n_tests++;
      if (bus.TState !== 3'(seq[i])) begin n_fail++; $display("FAIL lda_tstate[%0d] got=%0d want=%0d", i, bus.TState, seq[i]); end
      n_tests++;
      if (act_w !== exp_w) begin n_fail++; $display("FAIL lda_word[%0d] got=%b want=%b", i, act_w, exp_w); end
      if (act_w[W_LA]) begin
        la++;
        n_tests++;
        if (bus.TState !== 3'd4 || !act_w[W_RAM]) begin n_fail++; $display("FAIL lda_latch_a_at got T=%0d ram=%b want T=4 ram=1", bus.TState, act_w[W_RAM]); end
      end
      if (i < 4) advance();
    end
    n_tests++;
    if (la != 1) begin n_fail++; $display("FAIL lda_latch_a_count got=%0d want=1", la); end
  endtask

  task automatic test_sub();
    int la = 0;
    do_clear();
    bus.Run = 1; bus.StepMode = 0; bus.Opcode = SUB;
    for (int i = 0; i < 5; i++) begin
      sample();
      n_tests++;
      if (act_w !== exp_w) begin n_fail++; $display("FAIL sub_word[%0d] got=%b want=%b", i, act_w, exp_w); end
      if (act_w[W_LA]) la++;
      if (i == 4) begin
        n_tests++;
        if (!(act_w[W_ALU] && act_w[W_SUB] && act_w[W_LA]) || bus.TState !== 3'd5) begin
          n_fail++; $display("FAIL sub_t5 got alu=%b sub=%b la=%b T=%0d want 1 1 1 T=5", act_w[W_ALU], act_w[W_SUB], act_w[W_LA], bus.TState);
        end
      end
      advance();
    end
    n_tests++;
    if (la != 1 || bus.TState !== 3'd1) begin n_fail++; $display("FAIL sub_end got la_count=%0d T=%0d want 1 T=1", la, bus.TState); end
  endtask

  task automatic test_hlt();
    do_clear();
    bus.Run = 1; bus.StepMode = 0; bus.Opcode = HLT;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    n_tests++;
    if (bus.Halted !== 1'b1 || bus.TState !== 3'd3) begin n_fail++; $display("FAIL hlt_enter got H=%b T=%0d want H=1 T=3", bus.Halted, bus.TState); end
    for (int i = 0; i < 20; i++) begin
      bus.StepMode = 1'($urandom); bus.StepPulse = 1'($urandom); bus.Opcode = 4'($urandom);
      sample();
      n_tests++;
      if (act_w !== 13'd0 || bus.Halted !== 1'b1 || bus.TState !== 3'd3) begin
        n_fail++; $display("FAIL hlt_hold[%0d] got w=%b H=%b T=%0d want 0 H=1 T=3", i, act_w, bus.Halted, bus.TState);
      end
      advance();
    end
    do_clear();
    n_tests++;
    if (bus.Halted !== 1'b0 || bus.TState !== 3'd1) begin n_fail++; $display("FAIL hlt_exit got H=%b T=%0d want H=0 T=1", bus.Halted, bus.TState); end
  endtask

  task automatic test_step();
    int mar = 0;
    bus.StepMode = 1; bus.StepPulse = 0; bus.Run = 1; bus.Opcode = LDA;
    do_clear();
    bus.StepPulse = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      n_tests++;
      if (act_w !== exp_w) begin n_fail++; $display("FAIL step_word[%0d] got=%b want=%b", i, act_w, exp_w); end
      if (act_w[W_MAR]) mar++;
      advance();
    end
    n_tests++;
    if (mar != 1 || bus.TState !== 3'd2) begin n_fail++; $display("FAIL step_single got mar=%0d T=%0d want 1 T=2", mar, bus.TState); end
    bus.StepPulse = 0; sample(); advance();
    bus.StepPulse = 1; sample(); advance();
    n_tests++;
    if (bus.TState !== 3'd3) begin n_fail++; $display("FAIL step_second got T=%0d want 3", bus.TState); end
  endtask

  task automatic test_clear_mid();
    bus.StepMode = 0; bus.StepPulse = 0; bus.Run = 1; bus.Opcode = ADD;
    do_clear();
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    clr = 1;
    sample();
    n_tests++;
    if (act_w !== 13'd0 || bus.TState !== 3'd4) begin n_fail++; $display("FAIL clrmid_outputs got w=%b T=%0d want 0 T=4", act_w, bus.TState); end
    advance();
    clr = 0;
    sample();
    n_tests++;
    if (bus.TState !== 3'd1 || act_w !== exp_w) begin n_fail++; $display("FAIL clrmid_after got T=%0d w=%b want T=1 w=%b", bus.TState, act_w, exp_w); end
    advance();
  endtask

  task automatic test_random();
    int prints = 0;
    bus.Run = 1; bus.StepMode = 0; bus.StepPulse = 0; bus.Opcode = NOP;
    do_clear();
    m_fetched = 0; inc_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (m_t == 1 && !m_halt && ($urandom % 2 == 0)) begin
        bus.Opcode = 4'($urandom);
        if (bus.Opcode == HLT && ($urandom % 4 != 0)) bus.Opcode = 4'h5;
      end
      bus.Run       = ($urandom % 8 != 0);
      bus.StepMode  = ($urandom % 4 == 0);
      bus.StepPulse = 1'($urandom);
      clr           = (m_halt && ($urandom % 6 == 0)) || ($urandom % 200 == 0);
      sample();
      n_tests++;
      if (act_w !== exp_w || bus.TState !== 3'(m_t) || bus.Halted !== m_halt) begin
        n_fail++;
        if (prints++ < 10) $display("FAIL rand[%0d] op=%h got w=%b T=%0d H=%b want w=%b T=%0d H=%b",
                                    c, bus.Opcode, act_w, bus.TState, bus.Halted, exp_w, m_t, m_halt);
      end
      n_tests++;
      if ($countones(act_w[12:8]) > 1) begin
        n_fail++;
        if (prints++ < 10) $display("FAIL rand_bus_contention[%0d] got en=%b want at most one", c, act_w[12:8]);
      end
      advance();
    end
    clr = 0;
    n_tests++;
    if (inc_seen != m_fetched) begin n_fail++; $display("FAIL rand_incpc_count got=%0d want=%0d", inc_seen, m_fetched); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1;
    bus.Run = 0; bus.StepMode = 0; bus.StepPulse = 0; bus.Opcode = NOP;
    test_reset();
    test_lda();
    test_sub();
    test_hlt();
    test_step();
    test_clear_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
